// File: rtl/fetch_queue_if.sv
// Dequeue side of the fetch queue: head entry, valid/ready handshake and occupancy.
// The master drives the head; the slave (IF/ID stage) returns ready_i.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic            valid_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] instr_o;
    logic            ready_i;
    logic [CW-1:0]   count_o;

    modport master (output valid_o, output pc_o, output instr_o, output count_o, input ready_i);
    modport slave  (input valid_o, input pc_o, input instr_o, input count_o, output ready_i);
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, reads combinational imem and
// buffers {pc, instr} pairs in a DEPTH-entry FIFO with single-cycle redirect/flush.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              halt_i,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic [XLEN-1:0]   imem_addr_o,
    input  logic [XLEN-1:0]   imem_instr_i,
    fetch_queue_if.master     deq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t          storage [DEPTH];
    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    // Push never looks at ready_i, so a full queue stays full for a cycle even
    // when the head is popped; this keeps ready_i off the fetch path.
    assign push = !rst_i && !redirect_i && !halt_i && (count < CW'(DEPTH));
    assign pop  = deq.valid_o && deq.ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            // NOTE: storage is cleared on reset so pc_o/instr_o are never X
            // while the queue is empty; this costs a reset mux per storage bit.
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr_i};
                wr_ptr          <= wr_ptr + PW'(1);
                fetch_pc        <= fetch_pc + XLEN'(PC_STEP);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign imem_addr_o = fetch_pc;
    assign deq.valid_o = (count != '0);
    assign deq.pc_o    = storage[rd_ptr].pc;
    assign deq.instr_o = storage[rd_ptr].instr;
    assign deq.count_o = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a directed vector table on a DEPTH=4 instance
// plus hand-written fill/drain and pointer-wrap sequences on a DEPTH=8 instance.
module tb_fetch_queue;
    localparam int XLEN = 32;
    localparam logic [31:0] RPC8 = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // DEPTH=4, RESET_PC=0 instance
    logic        rst4, redir4, halt4;
    logic [31:0] rpc4, addr4, instr4;
    fetch_queue_if #(.XLEN(XLEN), .DEPTH(4)) q4 ();
    fetch_queue #(.XLEN(XLEN), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst4), .halt_i(halt4), .redirect_i(redir4),
        .redirect_pc_i(rpc4), .imem_addr_o(addr4), .imem_instr_i(instr4), .deq(q4.master)
    );
    assign instr4 = mem_word(addr4);

    // DEPTH=8, RESET_PC=0x1000 instance
    logic        rst8, redir8, halt8;
    logic [31:0] rpc8, addr8, instr8;
    fetch_queue_if #(.XLEN(XLEN), .DEPTH(8)) q8 ();
    fetch_queue #(.XLEN(XLEN), .DEPTH(8), .RESET_PC(RPC8), .PC_STEP(4)) dut8 (
        .clk_i(clk), .rst_i(rst8), .halt_i(halt8), .redirect_i(redir8),
        .redirect_pc_i(rpc8), .imem_addr_o(addr8), .imem_instr_i(instr8), .deq(q8.master)
    );
    assign instr8 = mem_word(addr8);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        redirect;
        logic        halt;
        logic        ready;
        logic [31:0] redirect_pc;
        int          exp_count;
        logic        exp_valid;
        logic        chk_head;   // compare pc_o/instr_o on this row
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rd, input logic h, input logic rdy,
                       input logic [31:0] rpc, input int cnt, input logic v,
                       input logic chk, input logic [31:0] pc, input logic [31:0] addr);
        vec_t t;
        t = '{rst: r, redirect: rd, halt: h, ready: rdy, redirect_pc: rpc, exp_count: cnt,
              exp_valid: v, chk_head: chk, exp_pc: pc, exp_addr: addr};
        vecs.push_back(t);
    endtask

    initial begin
        logic [31:0] exp_instr;

        rst4 = 1'b1; redir4 = 1'b0; halt4 = 1'b0; rpc4 = '0; q4.ready_i = 1'b0;
        rst8 = 1'b1; redir8 = 1'b0; halt8 = 1'b0; rpc8 = '0; q8.ready_i = 1'b0;

        //   rst redir halt rdy  rpc            cnt v  chk pc             addr
        add(1, 0, 0, 0, 32'h0,         0, 0, 1, 32'h0,         32'h0);        // reset state
        add(0, 0, 0, 1, 32'h0,         1, 1, 1, 32'h0,         32'h4);        // 1-cycle fetch latency
        add(0, 0, 0, 1, 32'h0,         1, 1, 1, 32'h4,         32'h8);        // streaming, count 1
        add(0, 0, 0, 1, 32'h0,         1, 1, 1, 32'h8,         32'hC);
        add(0, 0, 0, 1, 32'h0,         1, 1, 1, 32'hC,         32'h10);
        add(1, 0, 0, 0, 32'h0,         0, 0, 1, 32'h0,         32'h0);        // reset mid-run
        add(0, 0, 0, 0, 32'h0,         1, 1, 1, 32'h0,         32'h4);        // fill with ready=0
        add(0, 0, 0, 0, 32'h0,         2, 1, 1, 32'h0,         32'h8);
        add(0, 0, 0, 0, 32'h0,         3, 1, 1, 32'h0,         32'hC);
        add(0, 0, 0, 0, 32'h0,         4, 1, 1, 32'h0,         32'h10);
        add(0, 0, 0, 0, 32'h0,         4, 1, 1, 32'h0,         32'h10);       // full: addr frozen
        add(0, 0, 0, 0, 32'h0,         4, 1, 1, 32'h0,         32'h10);
        add(0, 0, 0, 1, 32'h0,         3, 1, 1, 32'h4,         32'h10);       // pop from full, no push
        add(0, 0, 0, 1, 32'h0,         3, 1, 1, 32'h8,         32'h14);
        add(0, 0, 0, 1, 32'h0,         3, 1, 1, 32'hC,         32'h18);
        add(0, 0, 0, 1, 32'h0,         3, 1, 1, 32'h10,        32'h1C);
        add(0, 0, 0, 0, 32'h0,         4, 1, 1, 32'h10,        32'h20);       // refill to full
        add(0, 1, 0, 0, 32'h100,       0, 0, 0, 32'h0,         32'h100);      // redirect flushes full queue
        add(0, 0, 0, 0, 32'h0,         1, 1, 1, 32'h100,       32'h104);      // target valid 2 cycles later
        add(0, 0, 0, 0, 32'h0,         2, 1, 1, 32'h100,       32'h108);
        add(0, 0, 1, 1, 32'h0,         1, 1, 1, 32'h104,       32'h108);      // halt: pops continue
        add(0, 0, 1, 1, 32'h0,         0, 0, 0, 32'h0,         32'h108);
        add(0, 0, 1, 1, 32'h0,         0, 0, 0, 32'h0,         32'h108);      // halted and empty
        add(0, 0, 0, 1, 32'h0,         1, 1, 1, 32'h108,       32'h10C);      // resume at held PC
        add(0, 0, 1, 0, 32'h0,         1, 1, 1, 32'h108,       32'h10C);      // halt holds PC and queue
        add(1, 1, 0, 1, 32'h200,       0, 0, 1, 32'h0,         32'h0);        // reset beats redirect
        add(0, 0, 0, 1, 32'h0,         1, 1, 1, 32'h0,         32'h4);
        add(0, 1, 1, 1, 32'hFFFF_FFF8, 0, 0, 0, 32'h0,         32'hFFFF_FFF8); // redirect ignores halt and pop
        add(0, 0, 0, 0, 32'h0,         1, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        add(0, 0, 0, 0, 32'h0,         2, 1, 1, 32'hFFFF_FFF8, 32'h0);        // fetch PC wraps
        add(0, 0, 0, 1, 32'h0,         2, 1, 1, 32'hFFFF_FFFC, 32'h4);
        add(0, 0, 0, 1, 32'h0,         2, 1, 1, 32'h0,         32'h8);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst4 = vecs[i].rst; redir4 = vecs[i].redirect; halt4 = vecs[i].halt;
            q4.ready_i = vecs[i].ready; rpc4 = vecs[i].redirect_pc;
            @(posedge clk);
            #1;
            check($sformatf("v%0d count", i), 32'(q4.count_o), 32'(vecs[i].exp_count));
            check($sformatf("v%0d valid", i), 32'(q4.valid_o), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d imem_addr", i), addr4, vecs[i].exp_addr);
            if (vecs[i].chk_head) begin
                exp_instr = vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'h0;
                check($sformatf("v%0d pc", i), q4.pc_o, vecs[i].exp_pc);
                check($sformatf("v%0d instr", i), q4.instr_o, exp_instr);
            end
        end

        // DEPTH=8: reset, fill to full, then stream long enough to wrap both pointers.
        @(negedge clk);
        rst8 = 1'b1; q8.ready_i = 1'b0;
        @(posedge clk);
        #1;
        check("d8 reset count", 32'(q8.count_o), 32'd0);
        check("d8 reset addr", addr8, RPC8);
        check("d8 reset pc", q8.pc_o, 32'h0);
        check("d8 reset instr", q8.instr_o, 32'h0);

        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            rst8 = 1'b0; q8.ready_i = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("d8 fill%0d count", k), 32'(q8.count_o), 32'((k < 8) ? k : 8));
            check($sformatf("d8 fill%0d addr", k), addr8, RPC8 + 32'(4 * ((k < 8) ? k : 8)));
            check($sformatf("d8 fill%0d pc", k), q8.pc_o, RPC8);
        end

        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            q8.ready_i = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("d8 drain%0d count", k), 32'(q8.count_o), 32'd7);
            check($sformatf("d8 drain%0d pc", k), q8.pc_o, RPC8 + 32'(4 * k));
            check($sformatf("d8 drain%0d instr", k), q8.instr_o, mem_word(RPC8 + 32'(4 * k)));
            check($sformatf("d8 drain%0d addr", k), addr8, RPC8 + 32'h20 + 32'(4 * (k - 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
